// File: rtl/sc_stoch2bin.sv
// Stochastic-to-binary converter: counts ones over 2^WIDTH valid samples,
// rescales by SCALE_SHIFT with saturation, and hands the result off via valid/ready.
module sc_stoch2bin #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  localparam int unsigned CW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + 1 + SCALE_SHIFT;
  localparam logic [CW-1:0] LAST_IDX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [SW-1:0] MAX_VAL  = SW'({WIDTH{1'b1}});

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    ones_q;
  logic [CW-1:0]    samp_q;
  logic [WIDTH-1:0] result_q;
  logic             valid_q;
  logic             busy_q;

  logic             last_sample;
  logic [CW-1:0]    ones_d;
  logic [SW-1:0]    scaled;
  logic [WIDTH-1:0] result_d;

  // The final sample is folded into the count combinationally so the result
  // can be registered on the same edge that accepts it.
  always_comb begin
    last_sample = bit_valid && (samp_q == LAST_IDX);
    ones_d      = ones_q + CW'(bit_in);
    scaled      = SW'(ones_d) << SCALE_SHIFT;
    if (scaled > MAX_VAL) begin
      result_d = '1;
    end else begin
      result_d = scaled[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      samp_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COUNT;
            ones_q  <= '0;
            samp_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        COUNT: begin
          if (bit_valid) begin
            samp_q <= samp_q + CW'(1);
            ones_q <= ones_d;
            if (last_sample) begin
              state_q  <= DONE;
              result_q <= result_d;
              valid_q  <= 1'b1;
              busy_q   <= 1'b0;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            valid_q <= 1'b0;
            if (start) begin
              state_q <= COUNT;
              ones_q  <= '0;
              samp_q  <= '0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

endmodule
